// File: rtl/hilo_div.sv
// hilo_div: HI/LO register pair with an attached iterative restoring divider.
//
// HI and LO are independent WIDTH-bit registers, each with its own write
// enable. The divider takes WIDTH cycles of CALC, one restoring quotient bit
// per cycle on operand magnitudes. It then spends one FINISH cycle, in which
// it writes HI=remainder and LO=quotient and pulses div_done.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   we_hi/whi    HI architectural write enable / data
//   we_lo/wlo    LO architectural write enable / data
//   rhi/rlo      HI/LO read data
//   div_start    start a division (sampled only in IDLE)
//   div_signed   1 = two's-complement, 0 = unsigned (sampled with div_start)
//   div_dividend dividend (sampled with div_start)
//   div_divisor  divisor (sampled with div_start)
//   div_cancel   abort the division in progress (also blocks a start in IDLE)
//   div_busy     high in CALC and FINISH
//   div_done     one-cycle pulse when the result is written to HI/LO
//
// Build option: define HILO_FWD_EN for combinational read bypass. When it is
// defined, rhi/rlo show this cycle's write data or the divider result. When it
// is undefined, rhi/rlo are the register outputs only.
module hilo_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] whi,
  input  logic [WIDTH-1:0] wlo,
  output logic [WIDTH-1:0] rhi,
  output logic [WIDTH-1:0] rlo,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_dividend,
  input  logic [WIDTH-1:0] div_divisor,
  input  logic             div_cancel,
  output logic             div_busy,
  output logic             div_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder magnitude
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dsr_q, dsr_d;   // divisor magnitude
  logic             qneg_q, qneg_d; // quotient must be negated
  logic             rneg_q, rneg_d; // remainder must be negated
  logic             dz_q, dz_d;     // divisor was zero

  // Operand sign and magnitude, as seen at the start edge.
  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;

  assign dvd_neg = div_signed & div_dividend[WIDTH-1];
  assign dsr_neg = div_signed & div_divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -div_dividend : div_dividend;
  assign dsr_mag = dsr_neg ? -div_divisor : div_divisor;

  // One restoring step. The remainder is always below the divisor, so the
  // trial value fits in WIDTH+1 bits and the top bit of diff is the borrow.
  logic [WIDTH:0] trial, diff;
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dsr_q};

  // Final sign fix-up. A zero divisor leaves the remainder equal to the
  // dividend magnitude, so the sign fix-up restores the dividend in HI. Only
  // LO needs the all-ones override, because the signed fix-up would otherwise
  // negate it.
  logic [WIDTH-1:0] rem_res, quo_res, lo_res;
  assign rem_res = rneg_q ? -rem_q : rem_q;
  assign quo_res = qneg_q ? -quo_q : quo_q;
  assign lo_res  = dz_q ? '1 : quo_res;

  logic commit;
  assign commit = (state_q == S_FINISH) && !div_cancel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (div_start && !div_cancel) begin
          state_d = S_CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = dvd_mag;
          dsr_d   = dsr_mag;
          qneg_d  = dvd_neg ^ dsr_neg;
          rneg_d  = dvd_neg;
          dz_d    = (div_divisor == '0);
        end
      end
      S_CALC: begin
        if (div_cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == LAST_ITER) begin
            state_d = S_FINISH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Architectural writes override the divider result half by half.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we_hi)       hi_d = whi;
    else if (commit) hi_d = rem_res;
    if (we_lo)       lo_d = wlo;
    else if (commit) lo_d = lo_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign div_busy = (state_q != S_IDLE);
  assign div_done = commit;

`ifdef HILO_FWD_EN
  // The next-state values already encode write-over-divider priority.
  assign rhi = hi_d;
  assign rlo = lo_d;
`else
  assign rhi = hi_q;
  assign rlo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_div.sv
// tb_hilo_div: self-checking bench for hilo_div (WIDTH=32). Directed cases
// and random divisions are checked against a reference built from plain
// SystemVerilog arithmetic, plus a model of the HI/LO register contents.
module tb_hilo_div;
  localparam int W    = 32;
  localparam int NONE = 9999;

`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         we_hi, we_lo, div_start, div_signed, div_cancel;
  logic [W-1:0] whi, wlo, div_dividend, div_divisor;
  logic [W-1:0] rhi, rlo;
  logic         div_busy, div_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [W-1:0] m_hi, m_lo;   // expected HI/LO register contents

  always #5 clk = ~clk;

  hilo_div #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .we_hi(we_hi), .we_lo(we_lo), .whi(whi), .wlo(wlo),
    .rhi(rhi), .rlo(rlo), .div_start(div_start), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_cancel(div_cancel), .div_busy(div_busy), .div_done(div_done)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference quotient/remainder from the language's own division operators.
  function automatic void ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    logic [W-1:0] min_v;
    min_v = {1'b1, {(W-1){1'b0}}};
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == min_v && b == '1) begin
      q = min_v;
      r = '0;
    end else begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end
  endfunction

  task automatic idle_inputs();
    we_hi      = 1'b0;
    we_lo      = 1'b0;
    div_start  = 1'b0;
    div_cancel = 1'b0;
  endtask

  // One architectural write cycle followed by one quiet cycle.
  task automatic wr(input string tag, input bit eh, input logic [W-1:0] hv,
                    input bit el, input logic [W-1:0] lv);
    logic [W-1:0] nx_hi, nx_lo;
    @(negedge clk);
    idle_inputs();
    we_hi = eh; whi = hv; we_lo = el; wlo = lv;
    nx_hi = eh ? hv : m_hi;
    nx_lo = el ? lv : m_lo;
    #1;
    chk({tag, " rhi same"}, rhi, FWD ? nx_hi : m_hi);
    chk({tag, " rlo same"}, rlo, FWD ? nx_lo : m_lo);
    m_hi = nx_hi;
    m_lo = nx_lo;
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, " rhi next"}, rhi, m_hi);
    chk({tag, " rlo next"}, rlo, m_lo);
    $display("wr   %-10s hi=%h lo=%h", tag, m_hi, m_lo);
  endtask

  // Division starting in cycle 0, observed for W+4 cycles. Optional events:
  // cancel in cycle cancel_at, a second start in cycle restart_at, a HI write
  // in the FINISH cycle, and an asynchronous reset pulse in cycle rst_at.
  task automatic run_div(input string tag, input bit sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int cancel_at, input int restart_at,
                         input bit hi_in_fin, input int rst_at);
    logic [W-1:0] q, r, nx_hi, nx_lo;
    bit exp_busy, exp_done;
    ref_div(sgn, a, b, q, r);
    for (int c = 0; c <= W + 3; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 0) begin
        div_start = 1'b1; div_signed = sgn; div_dividend = a; div_divisor = b;
      end
      if (c == restart_at) begin
        div_start = 1'b1; div_signed = ~sgn; div_dividend = ~a; div_divisor = b + 3;
      end
      if (c == cancel_at) div_cancel = 1'b1;
      if (hi_in_fin && c == W + 1) begin
        we_hi = 1'b1; whi = 32'hA5;
      end
      exp_busy = (c >= 1) && (c <= W + 1) && (c <= cancel_at) && (c <= rst_at);
      exp_done = (c == W + 1) && (cancel_at > W + 1) && (rst_at > W + 1);
      nx_hi = we_hi ? whi : (exp_done ? r : m_hi);
      nx_lo = we_lo ? wlo : (exp_done ? q : m_lo);
      #1;
      chk($sformatf("%s busy c%0d", tag, c), W'(div_busy), W'(exp_busy));
      chk($sformatf("%s done c%0d", tag, c), W'(div_done), W'(exp_done));
      chk($sformatf("%s rhi c%0d", tag, c), rhi, FWD ? nx_hi : m_hi);
      chk($sformatf("%s rlo c%0d", tag, c), rlo, FWD ? nx_lo : m_lo);
      m_hi = nx_hi;
      m_lo = nx_lo;
      if (c == rst_at) begin
        #1 rst = 1'b1;
        #1;
        chk({tag, " rst rhi"}, rhi, '0);
        chk({tag, " rst rlo"}, rlo, '0);
        chk({tag, " rst busy"}, W'(div_busy), '0);
        chk({tag, " rst done"}, W'(div_done), '0);
        #1 rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
      end
    end
    @(negedge clk);
    idle_inputs();
    $display("div  %-10s s=%0d a=%h b=%h -> hi=%h lo=%h", tag, sgn, a, b, m_hi, m_lo);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    whi = '0; wlo = '0; div_signed = 1'b0; div_dividend = '0; div_divisor = '0;
    m_hi = '0; m_lo = '0;
    #3;
    chk("reset rhi", rhi, '0);
    chk("reset rlo", rlo, '0);
    chk("reset busy", W'(div_busy), '0);
    chk("reset done", W'(div_done), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("rst  released");

    wr("lo_fwd", 1'b0, '0, 1'b1, 32'hDEADBEEF);
    wr("hi_only", 1'b1, 32'h1234, 1'b0, '0);

    run_div("u100_7", 1'b0, 32'd100, 32'd7, NONE, NONE, 1'b0, NONE);
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, NONE, NONE, 1'b0, NONE);
    run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, NONE, NONE, 1'b0, NONE);
    run_div("u5_0", 1'b0, 32'd5, 32'd0, NONE, NONE, 1'b0, NONE);
    run_div("s_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, NONE, NONE, 1'b0, NONE);
    run_div("s_13_m4", 1'b1, 32'd13, 32'hFFFFFFFC, NONE, NONE, 1'b0, NONE);

    wr("preset", 1'b1, 32'h11, 1'b1, 32'h22);
    run_div("cancel10", 1'b0, 32'd1000, 32'd3, 10, 5, 1'b0, NONE);
    run_div("restart5", 1'b0, 32'd1000, 32'd3, NONE, 5, 1'b0, NONE);
    run_div("cancel_fin", 1'b1, 32'hFFFFFFB3, 32'd5, W + 1, NONE, 1'b0, NONE);
    run_div("whi_fin", 1'b0, 32'd100, 32'd7, NONE, NONE, 1'b1, NONE);
    run_div("rst_mid", 1'b0, 32'h12345678, 32'h123, NONE, NONE, 1'b0, 20);

    // Start together with cancel in IDLE must not launch a division.
    @(negedge clk);
    idle_inputs();
    div_start = 1'b1; div_cancel = 1'b1; div_signed = 1'b0;
    div_dividend = 32'd9; div_divisor = 32'd2;
    for (int c = 0; c <= W + 3; c++) begin
      #1;
      chk($sformatf("startcancel busy c%0d", c), W'(div_busy), '0);
      chk($sformatf("startcancel done c%0d", c), W'(div_done), '0);
      chk($sformatf("startcancel rlo c%0d", c), rlo, m_lo);
      @(negedge clk);
      idle_inputs();
    end
    $display("idle start+cancel ignored");

    for (int i = 0; i < 10; i++) begin
      bit           sgn;
      logic [W-1:0] a, b;
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = $urandom;
        2:       b = -($urandom_range(1, 8));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div($sformatf("rand%0d", i), sgn, a, b, NONE, NONE, 1'b0, NONE);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hilo_div.md
HILO_DIV -- requirements
Module: hilo_div

Interface
REQ-001 The block SHALL have one parameter: WIDTH, 32, width of each of HI, LO and the divider operands (WIDTH >= 4).
REQ-002 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  clock, all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 we_hi  input  1  architectural write enable for HI.
REQ-006 we_lo  input  1  architectural write enable for LO.
REQ-007 whi  input  WIDTH  HI write data.
REQ-008 wlo  input  WIDTH  LO write data.
REQ-009 rhi  output  WIDTH  HI read data.
REQ-010 rlo  output  WIDTH  LO read data.
REQ-011 div_start  input  1  start a division; sampled only in IDLE.
REQ-012 div_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with div_start.
REQ-013 div_dividend  input  WIDTH  dividend; sampled with div_start.
REQ-014 div_divisor  input  WIDTH  divisor; sampled with div_start.
REQ-015 div_cancel  input  1  abort the division in progress.
REQ-016 div_busy  output  1  high in CALC and FINISH.
REQ-017 div_done  output  1  one-cycle pulse when the result is written to HI/LO.

Function
REQ-018 Each of HI and LO SHALL be a separate WIDTH-bit register with its own write enable; a write to one half SHALL leave the other half unchanged.
REQ-019 The divider SHALL implement the states IDLE, CALC and FINISH.
- IDLE: div_start=1 and div_cancel=0 -> CALC; operands and div_signed are latched at that edge.
- CALC: lasts exactly WIDTH cycles, one restoring quotient bit per cycle, on operand magnitudes.
- FINISH: lasts one cycle -> IDLE.
REQ-020 Latency: with div_start high in cycle 0, the block SHALL hold div_done=1 in cycle WIDTH+1, and SHALL write HI=remainder and LO=quotient at the end of that cycle.
REQ-021 For signed division, the quotient sign SHALL be the XOR of the operand signs and the remainder sign SHALL equal the dividend sign; all results SHALL be truncated to WIDTH bits.
REQ-022 For signed MIN / -1, the block SHALL produce LO=MIN and HI=0.
REQ-023 For a divisor of 0, the block SHALL use the normal latency and produce HI=dividend and LO=all ones, for both signed and unsigned division.
REQ-024 div_start in CALC or FINISH SHALL be ignored.
REQ-025 div_cancel in CALC or FINISH SHALL return the divider to IDLE at the next edge, with no HI/LO update and no div_done.
REQ-026 div_cancel together with div_start in IDLE SHALL win: the divider stays in IDLE.
REQ-027 An architectural write in the FINISH cycle SHALL take priority, per half, over the divider result; the divider result for that half is discarded, div_done still pulses.
REQ-028 Architectural writes during CALC SHALL proceed normally.

Reset
REQ-029 While rst=1, HI and LO SHALL be 0, the divider SHALL be in IDLE, the iteration counter SHALL be 0, and div_busy and div_done SHALL be 0, independent of clk.
REQ-030 When rst asserts mid-division, the block SHALL abandon the operation, with no div_done after reset release.

Configuration
REQ-031 The macro HILO_FWD_EN SHALL control read bypass; with it defined:
- rhi SHALL be combinational: whi if we_hi, else the divider HI result in FINISH if not overridden, else the HI register.
- rlo SHALL follow the same rule using wlo, we_lo and the divider LO result.
REQ-032 Without HILO_FWD_EN, rhi and rlo SHALL be the register outputs only, so a write is visible one cycle later.

Verification (WIDTH=32)
REQ-033 Unsigned 100 / 7, start in cycle 0 -> div_busy in cycles 1-33, div_done in cycle 33, then HI=2 and LO=14.
REQ-034 Signed 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD and HI=0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000 and HI=0.
REQ-035 Unsigned 5 / 0 -> HI=5 and LO=0xFFFFFFFF after 33 cycles.
REQ-036 Cancel at cycle 10 with HI=0x11 and LO=0x22 preset -> div_busy=0 from cycle 11, no div_done, HI/LO unchanged; div_start in cycle 5 ignored.
REQ-037 we_lo=1 with wlo=0xDEADBEEF -> rlo=0xDEADBEEF in the same cycle with HILO_FWD_EN, the next cycle without; we_hi in the FINISH cycle with whi=0xA5 -> HI=0xA5 and LO=quotient.
REQ-038 rst pulsed asynchronously at cycle 20 of a division -> all outputs 0 immediately, no div_done afterwards.
